// File: rtl/matrix_pkg.sv
// Shared constants, FSM encoding and RGB bit order for the HUB75 frame buffer.
package matrix_pkg;

  localparam int PANEL_W   = 64;
  localparam int PANEL_H   = 32;
  localparam int ROW_PAIRS = 16;

  typedef enum logic [1:0] {
    FB_IDLE      = 2'd0,
    FB_CLEAR     = 2'd1,
    FB_SWAP_WAIT = 2'd2
  } fb_state_t;

  // Bit positions inside a 3-bit {R,G,B} pixel
  localparam int RGB_R = 2;
  localparam int RGB_G = 1;
  localparam int RGB_B = 0;

endpackage

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module fb_bank_ram #(
  parameter int AW = 10,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_fb.sv
// Double-buffered RGB frame buffer feeding the HUB75 scan driver, with clear engine.
//   state        | meaning
//   FB_IDLE      | accepting pixel writes, launching clear/swap requests
//   FB_CLEAR     | zeroing one back-bank address per cycle, writes dropped
//   FB_SWAP_WAIT | waiting for the row counter to wrap 15->0, then flip banks
import matrix_pkg::*;

module matrix_fb #(
  parameter int W = PANEL_W,
  parameter int H = PANEL_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [$clog2(W)-1:0]   wr_x,
  input  logic [$clog2(H)-1:0]   wr_y,
  input  logic [2:0]             wr_rgb,
  input  logic                   clr_req,
  input  logic                   swap_req,
  output logic                   busy,
  output logic                   swap_done,
  input  logic [$clog2(W):0]     col,
  input  logic [$clog2(H)-2:0]   rows,
  output logic                   R0in,
  output logic                   G0in,
  output logic                   B0in,
  output logic                   R1in,
  output logic                   G1in,
  output logic                   B1in
);

  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int RW = YW - 1;
  localparam int AW = XW + RW;

  fb_state_t     state, state_nx;
  logic          front;
  logic          clr_pend, clr_pend_nx;
  logic          swap_pend, swap_pend_nx;
  logic          do_swap;
  logic [AW-1:0] clr_addr;
  logic [RW-1:0] rows_q;
  logic          front_rd;
  logic          valid_rd;
  logic          boundary;
  logic          clearing;
  logic          wr_act;
  logic [AW-1:0] waddr;
  logic [2:0]    wdata;
  logic [AW-1:0] raddr;
  logic [2:0]    rd_q [2][2];

  assign boundary = (&rows_q) && (rows == '0);
  assign clearing = (state == FB_CLEAR);
  assign wr_act   = wr_en && (state == FB_IDLE);
  assign busy     = (state != FB_IDLE) || clr_pend || swap_pend;

  always_comb begin
    state_nx     = state;
    clr_pend_nx  = clr_pend  || (clr_req  && (state != FB_IDLE));
    swap_pend_nx = swap_pend || (swap_req && (state != FB_IDLE));
    do_swap      = 1'b0;
    case (state)
      FB_IDLE: begin
        if (clr_req || clr_pend) begin
          state_nx     = FB_CLEAR;
          clr_pend_nx  = 1'b0;
          swap_pend_nx = swap_pend || swap_req;
        end else if (swap_req || swap_pend) begin
          state_nx     = FB_SWAP_WAIT;
          swap_pend_nx = 1'b1;
        end
      end
      FB_CLEAR: begin
        // clr_addr wraps back to 0 here, so a chained clear starts clean
        if (&clr_addr) begin
          if (clr_pend_nx) begin
            state_nx    = FB_CLEAR;
            clr_pend_nx = 1'b0;
          end else if (swap_pend_nx) begin
            state_nx = FB_SWAP_WAIT;
          end else begin
            state_nx = FB_IDLE;
          end
        end
      end
      FB_SWAP_WAIT: begin
        if (boundary) begin
          state_nx     = FB_IDLE;
          do_swap      = 1'b1;
          swap_pend_nx = 1'b0;
        end
      end
      default: state_nx = FB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FB_IDLE;
      front     <= 1'b0;
      clr_pend  <= 1'b0;
      swap_pend <= 1'b0;
      clr_addr  <= '0;
      rows_q    <= '0;
      swap_done <= 1'b0;
      front_rd  <= 1'b0;
      valid_rd  <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_pend  <= clr_pend_nx;
      swap_pend <= swap_pend_nx;
      if (clearing) clr_addr <= clr_addr + AW'(1);
      rows_q    <= rows;
      swap_done <= do_swap;
      if (do_swap) front <= ~front;
      front_rd  <= front;
      valid_rd  <= ~col[XW];
    end
  end

  assign waddr = clearing ? clr_addr : {wr_y[RW-1:0], wr_x};
  assign wdata = clearing ? 3'b000 : wr_rgb;
  assign raddr = {rows, col[XW-1:0]};

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic we;
      assign we = (front != 1'(b)) &&
                  (clearing || (wr_act && (wr_y[YW-1] == 1'(h))));
      fb_bank_ram #(.AW(AW), .DW(3)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rd_q[b][h])
      );
    end
  end

  // Terminal-count columns and reset both force the pins low
  always_comb begin
    {R0in, G0in, B0in, R1in, G1in, B1in} = 6'b0;
    if (valid_rd) begin
      R0in = rd_q[front_rd][0][RGB_R];
      G0in = rd_q[front_rd][0][RGB_G];
      B0in = rd_q[front_rd][0][RGB_B];
      R1in = rd_q[front_rd][1][RGB_R];
      G1in = rd_q[front_rd][1][RGB_G];
      B1in = rd_q[front_rd][1][RGB_B];
    end
  end

endmodule

// File: tb/tb_matrix_fb.sv
// Self-checking bench for matrix_fb against a pixel-array model of both banks.
module tb_matrix_fb;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_rgb;
  logic       clr_req;
  logic       swap_req;
  logic       busy;
  logic       swap_done;
  logic [6:0] col;
  logic [3:0] rows;
  logic       R0in, G0in, B0in, R1in, G1in, B1in;
  logic [5:0] outs;

  matrix_fb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clr_req(clr_req), .swap_req(swap_req), .busy(busy), .swap_done(swap_done),
    .col(col), .rows(rows),
    .R0in(R0in), .G0in(G0in), .B0in(B0in), .R1in(R1in), .G1in(G1in), .B1in(B1in)
  );

  always #5 clk = ~clk;
  assign outs = {R0in, G0in, B0in, R1in, G1in, B1in};

  logic [2:0] mem [2][32][64];
  int mf;
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_pix(input int f, input int r, input int c);
    if (c >= 64) return 6'b0;
    return {mem[f][r][c], mem[f][r+16][c]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_bank(input int b);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++) mem[b][y][x] = 3'b000;
  endtask

  task automatic read_chk(input string tag, input int r, input int c);
    int f;
    f = mf;
    rows = 4'(r);
    col = 7'(c);
    tick();
    chk(tag, 32'(outs), 32'(exp_pix(f, r, c)));
  endtask

  task automatic write_px(input int x, input int y, input logic [2:0] rgb);
    wr_en = 1'b1; wr_x = 6'(x); wr_y = 5'(y); wr_rgb = rgb;
    tick();
    wr_en = 1'b0;
    mem[1-mf][y][x] = rgb;
  endtask

  task automatic do_swap(input string tag);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rows = 4'd15;
    tick();
    rows = 4'd0;
    tick();
    chk(tag, 32'(swap_done), 32'd1);
    mf = 1 - mf;
    tick();
  endtask

  task automatic do_clear_swap();
    int bad;
    rows = 4'd3;
    clr_req = 1'b1; swap_req = 1'b1;
    tick();
    clr_req = 1'b0; swap_req = 1'b0;
    chk("clrswap_busy_rise", 32'(busy), 32'd1);
    bad = 0;
    for (int i = 1; i < 1024; i++) begin
      wr_en = 1'b0;
      if (i == 600) begin wr_en = 1'b1; wr_x = 6'd0; wr_y = 5'd0;  wr_rgb = 3'd7; end
      if (i == 601) begin wr_en = 1'b1; wr_x = 6'd0; wr_y = 5'd16; wr_rgb = 3'd5; end
      if (i == 700) begin
        wr_en = 1'b1; wr_x = 6'($urandom_range(0, 63)); wr_y = 5'($urandom_range(0, 31));
        wr_rgb = 3'($urandom_range(1, 7));
      end
      tick();
      if (busy !== 1'b1) bad++;
    end
    wr_en = 1'b0;
    chk("clrswap_busy_during_clear", 32'(bad), 32'd0);
    tick();
    chk("clrswap_busy_after_clear", 32'(busy), 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (busy !== 1'b1 || swap_done !== 1'b0) bad++;
    end
    chk("clrswap_wait_boundary", 32'(bad), 32'd0);
    rows = 4'd15;
    tick();
    rows = 4'd0;
    tick();
    chk("clrswap_swap_done", 32'(swap_done), 32'd1);
    mf = 1 - mf;
    zero_bank(mf);
    tick();
    chk("clrswap_swap_done_fall", 32'(swap_done), 32'd0);
    chk("clrswap_busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    int bad, sd_cnt, f, c, r;
    rst = 1'b1; wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    clr_req = 1'b0; swap_req = 1'b0; col = '0; rows = '0;
    mf = 0;
    for (int b = 0; b < 2; b++) zero_bank(b);
    repeat (3) tick();
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_swap_done", 32'(swap_done), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // simultaneous clear+swap twice leaves both banks zeroed, front back at 0
    do_clear_swap();
    bad = 0;
    for (int rr = 0; rr < 16; rr++)
      for (int cc = 0; cc < 64; cc++) begin
        rows = 4'(rr); col = 7'(cc);
        tick();
        if (outs !== 6'b0 || busy !== 1'b0) bad++;
      end
    chk("sweep_front_zero", 32'(bad), 32'd0);
    do_clear_swap();
    chk("front_parity", 32'(mf), 32'd0);

    // directed pixel pair in upper and lower halves
    rows = 4'd3;
    write_px(5, 3, 3'b100);
    write_px(5, 19, 3'b011);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_busy", 32'(busy), 32'd1);
    sd_cnt = 0;
    rows = 4'd15; tick(); if (swap_done) sd_cnt++;
    rows = 4'd0;  tick(); if (swap_done) sd_cnt++;
    mf = 1 - mf;
    rows = 4'd3; col = 7'd5;
    tick(); if (swap_done) sd_cnt++;
    chk("pixel_pair_model", 32'(outs), 32'(exp_pix(mf, 3, 5)));
    chk("pixel_pair_const", 32'(outs), 32'h23);
    for (int i = 0; i < 3; i++) begin tick(); if (swap_done) sd_cnt++; end
    chk("swap_done_once", 32'(sd_cnt), 32'd1);
    read_chk("col64_r3", 3, 64);
    for (int i = 0; i < 4; i++) read_chk("col_tc", $urandom_range(0, 15), $urandom_range(64, 127));

    // random back-bank fill, swap held off with rows parked at 7
    for (int i = 0; i < 40; i++)
      write_px($urandom_range(0, 63), $urandom_range(0, 31), 3'($urandom_range(0, 7)));
    rows = 4'd7;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      c = $urandom_range(0, 63);
      read_chk("hold_read_old_front", 7, c);
      if (swap_done !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("hold_no_swap", 32'(bad), 32'd0);
    rows = 4'd15;
    tick();
    rows = 4'd0;
    tick();
    chk("hold_swap_done", 32'(swap_done), 32'd1);
    mf = 1 - mf;
    tick();
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 15);
      c = ($urandom_range(0, 3) == 0) ? $urandom_range(64, 127) : $urandom_range(0, 63);
      read_chk("rand_read", r, c);
    end

    // clear alone takes exactly 1024 cycles
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bad = 0;
    for (int i = 1; i < 1024; i++) begin tick(); if (busy !== 1'b1) bad++; end
    chk("clear_busy_1024", 32'(bad), 32'd0);
    tick();
    chk("clear_busy_end", 32'(busy), 32'd0);
    zero_bank(1 - mf);
    do_swap("clear_then_swap");
    for (int i = 0; i < 100; i++) read_chk("post_clear_read", $urandom_range(0, 15), $urandom_range(0, 63));

    // reset mid-clear, with bank 0 in front showing a known pixel
    do begin
      write_px(2, 4, 3'b111);
      do_swap("setup_swap");
    end while (mf != 0);
    rows = 4'd4; col = 7'd2;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bad = 0;
    for (int i = 1; i < 500; i++) begin
      f = mf;
      tick();
      if (outs !== exp_pix(f, 4, 2)) bad++;
    end
    chk("pre_reset_reads", 32'(bad), 32'd0);
    chk("pre_reset_outs_lit", 32'(outs[5:3]), 32'd7);
    rst = 1'b1;
    #2;
    chk("async_rst_outs", 32'(outs), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_swap_done", 32'(swap_done), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    mf = 0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);
    read_chk("post_rst_mem_kept", 4, 2);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bad = 0;
    for (int i = 1; i < 1024; i++) begin tick(); if (busy !== 1'b1) bad++; end
    chk("post_rst_clear_busy", 32'(bad), 32'd0);
    tick();
    chk("post_rst_clear_end", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_fb.md
# matrix_fb

Double-buffered RGB frame buffer that feeds the HUB75 LED-matrix scan driver. Game/render logic writes 3-bit pixels into a back buffer. The scan driver presents its column and row-pair counters, and this block returns the registered upper-half and lower-half pixel bits (`R0in`…`B1in`). Buffer swaps happen only at a frame boundary, so the panel never shows a half-drawn frame. A sequential clear engine is included.

## Interface
Parameters:
- `W`, default 64: panel width in pixels (power of two).
- `H`, default 32: panel height in pixels, two halves of `H/2` rows each.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write one pixel to the back buffer this cycle.
- `wr_x`  in  6  pixel column 0..63.
- `wr_y`  in  5  pixel row 0..31.
- `wr_rgb`  in  3  {R,G,B} bits.
- `clr_req`  in  1  pulse: clear the back buffer to 0.
- `swap_req`  in  1  pulse: request front/back exchange.
- `busy`  out  1  clear in progress or swap pending.
- `swap_done`  out  1  one-cycle pulse when the swap takes effect.
- `col`  in  7  scan driver column counter (0..64).
- `rows`  in  4  scan driver row-pair index.
- `R0in`, `G0in`, `B0in`  out  1 each  front-buffer pixel (`rows`, `col`).
- `R1in`, `G1in`, `B1in`  out  1 each  front-buffer pixel (`rows`+16, `col`).

## Operation
- Storage is two banks, each split into an upper array and a lower array of 1024×3.
  - Address is {row[3:0], x[5:0]}.
  - `wr_y[4]` selects the lower array.
- `front` is a 1-bit register with reset value 0. The back bank is `!front`.
- Writes:
  - When `wr_en`=1 in IDLE, store `wr_rgb` to the back bank.
  - When `wr_en`=1 while in CLEAR, the write is dropped.
- The state machine has three states: IDLE, CLEAR, SWAP_WAIT.
  - IDLE goes to CLEAR on `clr_req`.
  - IDLE goes to SWAP_WAIT on `swap_req`.
  - If `clr_req` and `swap_req` arrive in the same cycle, go to CLEAR and latch `swap_pend`.
  - CLEAR writes 0 to address `clr_addr` (0..1023) in both back arrays each cycle. After address 1023 it goes to SWAP_WAIT if `swap_pend`, otherwise to IDLE.
  - SWAP_WAIT waits for the frame boundary, toggles `front`, pulses `swap_done`, clears `swap_pend`, and returns to IDLE.
  - Any `swap_req` or `clr_req` received outside IDLE is latched as a pending request and serviced in order: clear first, then swap.
- Frame boundary: `rows_q` (the registered `rows`) equals 15 and `rows` equals 0, i.e. the row counter wraps.
- `busy` = (state != IDLE) or any pending request.
- Read path:
  - When `col` < 64, outputs = front bank[{rows, col[5:0]}].
  - When `col` ≥ 64 (the driver's terminal count), outputs are 0.
- Reset values: state IDLE, `front` 0, all pending flags 0, all six RGB outputs 0, `busy` 0, `swap_done` 0.
- Reset mid-clear aborts the clear. Memory contents are not reset.

## Timing
- Read latency is 1 cycle: `col`/`rows` sampled at edge N produce outputs valid after edge N. The driver registers them again, giving 2 cycles total from counter to pin.
- Write-to-memory latency is 1 cycle. There is no read-during-write hazard, because reads and writes always target different banks.
- A clear takes exactly 1024 cycles. `busy` rises the cycle after `clr_req`.
- `swap_done` asserts the cycle after the boundary is detected, and `front` changes on the same edge.
- The next read after the swap uses the new front bank.

## Structure
- Shared package `matrix_pkg` holds:
  - constants `PANEL_W`=64, `PANEL_H`=32, `ROW_PAIRS`=16;
  - the state encoding `FB_IDLE`/`FB_CLEAR`/`FB_SWAP_WAIT`;
  - the RGB bit order.
- Sub-module `fb_bank_ram`: 1024×3 simple dual-port RAM with one write port and one registered read port. It is instantiated four times (2 banks × upper/lower).

## Test plan
- After reset, sweep `col` 0..63 with `rows`=0: all six outputs are 0 and `busy`=0.
- Write (x=5, y=3, rgb=3'b100) and (x=5, y=19, rgb=3'b011), then `swap_req`, then drive `rows` 15→0. Expected:
  - `swap_done` pulses once;
  - with `rows`=3, `col`=5 the next cycle shows R0in=1, G1in=1, B1in=1, all others 0.
- `col`=64 with any `rows`: all outputs are 0 one cycle later.
- `clr_req` and `swap_req` in the same cycle. Expected:
  - `busy` stays high for 1024 cycles of clearing plus the wait for the boundary;
  - writes during the clear are ignored;
  - after the swap, every front pixel reads 0.
- `swap_req` with `rows` held at 7: no `swap_done` and `front` unchanged until `rows` steps 15→0.
- Assert `rst` at clear cycle 500. Expected:
  - outputs, `busy` and `swap_done` are 0 immediately (asynchronously);
  - after release the FSM is in IDLE and a new `clr_req` completes in 1024 cycles.
